// File: rtl/armstrong_range_scanner_if.sv
// Scan request/response bundle for armstrong_range_scanner.
// master = requester/consumer side, slave = scanner side.
interface armstrong_range_scanner_if #(
    parameter int W     = 9,
    parameter int CNT_W = 4
);
    logic             start;
    logic [W-1:0]     range_lo;
    logic [W-1:0]     range_hi;
    logic             busy;
    logic             done;
    logic             found_valid;
    logic             found_ready;
    logic [W-1:0]     found_num;
    logic [CNT_W-1:0] found_count;

    modport master (
        output start, range_lo, range_hi, found_ready,
        input  busy, done, found_valid, found_num, found_count
    );

    modport slave (
        input  start, range_lo, range_hi, found_ready,
        output busy, done, found_valid, found_num, found_count
    );
endinterface

// File: rtl/armstrong_range_scanner.sv
// Sweeps [range_lo, range_hi] and streams every number equal to the
// sum of the cubes of its three decimal digits.
module armstrong_range_scanner #(
    parameter int W     = 9,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    armstrong_range_scanner_if.slave bus
);
    localparam int SUM_W = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HUND,
        S_TENS,
        S_SUM,
        S_EMIT,
        S_NEXT,
        S_FIN
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_cand;
    logic [W-1:0]     r_rem;
    logic [3:0]       r_h;
    logic [3:0]       r_t;
    logic [3:0]       r_u;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;
    logic             r_done;
    logic             r_valid;
    logic [W-1:0]     r_num;
    logic [CNT_W-1:0] r_found_count;

    logic [SUM_W-1:0] w_sum;
    logic             w_match;

    function automatic logic [SUM_W-1:0] cube(input logic [3:0] d);
        logic [SUM_W-1:0] c;
        c = '0;
        unique case (d)
            4'd0:    c = 12'd0;
            4'd1:    c = 12'd1;
            4'd2:    c = 12'd8;
            4'd3:    c = 12'd27;
            4'd4:    c = 12'd64;
            4'd5:    c = 12'd125;
            4'd6:    c = 12'd216;
            4'd7:    c = 12'd343;
            4'd8:    c = 12'd512;
            4'd9:    c = 12'd729;
            default: c = 12'd0;
        endcase
        return c;
    endfunction

    // Candidate is zero-extended so a 12-bit sum never aliases onto it
    assign w_sum   = cube(r_h) + cube(r_t) + cube(r_u);
    assign w_match = (w_sum == {{(SUM_W - W){1'b0}}, r_cand});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_hi          <= '0;
            r_cand        <= '0;
            r_rem         <= '0;
            r_h           <= '0;
            r_t           <= '0;
            r_u           <= '0;
            r_count       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_valid       <= 1'b0;
            r_num         <= '0;
            r_found_count <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_hi    <= bus.range_hi;
                        r_cand  <= bus.range_lo;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        if (bus.range_lo > bus.range_hi) r_state <= S_FIN;
                        else                             r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_rem   <= r_cand;
                    r_h     <= '0;
                    r_t     <= '0;
                    r_state <= S_HUND;
                end
                S_HUND: begin
                    if (r_rem >= W'(100)) begin
                        r_rem <= r_rem - W'(100);
                        r_h   <= r_h + 4'd1;
                    end else begin
                        r_state <= S_TENS;
                    end
                end
                S_TENS: begin
                    if (r_rem >= W'(10)) begin
                        r_rem <= r_rem - W'(10);
                        r_t   <= r_t + 4'd1;
                    end else begin
                        r_u     <= r_rem[3:0];
                        r_state <= S_SUM;
                    end
                end
                S_SUM: begin
                    if (w_match) begin
                        r_num   <= r_cand;
                        r_valid <= 1'b1;
                        r_count <= r_count + CNT_W'(1);
                        r_state <= S_EMIT;
                    end else begin
                        r_state <= S_NEXT;
                    end
                end
                S_EMIT: begin
                    if (bus.found_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    // Stop on hi before incrementing so 511 never wraps
                    if (r_cand == r_hi) begin
                        r_state <= S_FIN;
                    end else begin
                        r_cand  <= r_cand + W'(1);
                        r_state <= S_LOAD;
                    end
                end
                S_FIN: begin
                    r_found_count <= r_count;
                    r_done        <= 1'b1;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.found_valid = r_valid;
    assign bus.found_num   = r_num;
    assign bus.found_count = r_found_count;
endmodule

// File: tb/tb_armstrong_range_scanner.sv
// Directed bench for armstrong_range_scanner: range scans, backpressure,
// empty/degenerate ranges, ignored start and mid-scan reset.
module tb_armstrong_range_scanner;
    localparam int LIMIT = 20000;

    logic clk;
    logic rst_n;

    armstrong_range_scanner_if #(.W(9), .CNT_W(4)) vif ();

    armstrong_range_scanner #(.W(9), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    int hits[$];
    int exp_q[$];
    int done_cyc;
    bit got_done;
    bit saw_valid;
    bit unstable;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_hits(input string tag, input int e[$]);
        chk({tag, "_nhits"}, hits.size(), e.size());
        for (int i = 0; i < e.size(); i++) begin
            if (i < hits.size())
                chk($sformatf("%s_hit%0d", tag, i), hits[i], e[i]);
            else
                chk($sformatf("%s_hit%0d", tag, i), 32'hFFFF_FFFF, e[i]);
        end
    endtask

    task automatic scan(input logic [8:0] lo, input logic [8:0] hi,
                        input bit bp, input bit poke);
        int  cyc;
        int  stall;
        logic [8:0] held;
        hits.delete();
        got_done  = 0;
        saw_valid = 0;
        unstable  = 0;
        stall     = 0;
        held      = '0;
        cyc       = 0;
        vif.found_ready = !bp;
        @(posedge clk); #1;
        vif.start    = 1'b1;
        vif.range_lo = lo;
        vif.range_hi = hi;
        @(posedge clk); #1;
        vif.start = 1'b0;
        while (!got_done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (vif.done) got_done = 1;
            if (vif.found_valid) saw_valid = 1;
            if (vif.found_valid && vif.found_ready)
                hits.push_back(int'(vif.found_num));
            if (bp && vif.found_valid && !vif.found_ready) begin
                if (stall == 0) held = vif.found_num;
                else if (vif.found_num != held) unstable = 1;
                stall++;
            end
            @(posedge clk); #1;
            if (poke && cyc == 5) begin
                vif.start    = 1'b1;
                vif.range_lo = 9'd5;
                vif.range_hi = 9'd5;
            end else begin
                vif.start = 1'b0;
            end
            if (bp) begin
                if (vif.found_ready) begin
                    vif.found_ready = 1'b0;
                    stall = 0;
                end else if (stall >= 20) begin
                    vif.found_ready = 1'b1;
                end
            end
        end
        done_cyc = cyc;
        chk("done_seen", got_done, 1);
        @(negedge clk);
        chk("done_one_pulse", vif.done, 0);
        chk("busy_after_done", vif.busy, 0);
    endtask

    initial begin
        bit bad_done;
        n_tests = 0;
        n_fail  = 0;
        rst_n           = 1'b0;
        vif.start       = 1'b0;
        vif.range_lo    = '0;
        vif.range_hi    = '0;
        vif.found_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", vif.busy, 0);
        chk("rst_done", vif.done, 0);
        chk("rst_valid", vif.found_valid, 0);
        chk("rst_num", vif.found_num, 0);
        chk("rst_count", vif.found_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full sweep with a stray start while busy
        scan(9'd0, 9'd511, 1'b0, 1'b1);
        exp_q = '{0, 1, 153, 370, 371, 407};
        chk_hits("full", exp_q);
        chk("full_count", vif.found_count, 6);

        scan(9'd150, 9'd160, 1'b0, 1'b0);
        exp_q = '{153};
        chk_hits("r150", exp_q);
        chk("r150_count", vif.found_count, 1);

        scan(9'd360, 9'd380, 1'b1, 1'b0);
        exp_q = '{370, 371};
        chk_hits("bp", exp_q);
        chk("bp_stable", unstable, 0);
        chk("bp_count", vif.found_count, 2);

        scan(9'd200, 9'd100, 1'b0, 1'b0);
        chk("empty_fast", done_cyc <= 3, 1);
        chk("empty_novalid", saw_valid, 0);
        chk("empty_count", vif.found_count, 0);

        scan(9'd511, 9'd511, 1'b0, 1'b0);
        chk("top_nohit", hits.size(), 0);
        chk("top_count", vif.found_count, 0);

        scan(9'd407, 9'd407, 1'b0, 1'b0);
        exp_q = '{407};
        chk_hits("r407", exp_q);
        chk("r407_count", vif.found_count, 1);

        // Reset while 153 is being offered
        vif.found_ready = 1'b1;
        @(posedge clk); #1;
        vif.start    = 1'b1;
        vif.range_lo = 9'd0;
        vif.range_hi = 9'd511;
        @(posedge clk); #1;
        vif.start = 1'b0;
        begin
            int c;
            c = 0;
            while (!(vif.found_valid && vif.found_num == 9'd153)
                   && c < LIMIT) begin
                @(negedge clk);
                c++;
            end
            chk("mid_reach153", c < LIMIT, 1);
        end
        vif.found_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_busy", vif.busy, 0);
        chk("mid_valid", vif.found_valid, 0);
        chk("mid_num", vif.found_num, 0);
        chk("mid_count", vif.found_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (vif.done || vif.busy || vif.found_valid) bad_done = 1;
        end
        chk("mid_quiet", bad_done, 0);

        scan(9'd0, 9'd1, 1'b0, 1'b0);
        exp_q = '{0, 1};
        chk_hits("post", exp_q);
        chk("post_count", vif.found_count, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
